// File: rtl/timer_irq_handler_if.sv
// Bus between the pipeline/CSR side and the machine-mode timer interrupt responder.
// master: pipeline + csr_reg side (drives requests and CSR state, receives trap/CSR writes).
// slave : timer_irq_handler.
interface timer_irq_handler_if;
  // Request and CSR state
  logic        timer_interrupt;
  logic        csr_mstatus_mie;
  logic        csr_mstatus_mpie;
  logic        csr_mie_mtie;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  // Execute-stage status
  logic [31:0] pc_exe;
  logic        exe_valid;
  logic        stall;
  logic        is_mret;
  // Trap and CSR write-back
  logic        mip_mtip;
  logic        trap_req;
  logic [31:0] trap_pc;
  logic        mepc_we;
  logic [31:0] mepc_wdata;
  logic        mcause_we;
  logic [31:0] mcause_wdata;
  logic        mstatus_we;
  logic        mstatus_mie_wdata;
  logic        mstatus_mpie_wdata;

  modport master (
    output timer_interrupt, csr_mstatus_mie, csr_mstatus_mpie, csr_mie_mtie,
           csr_mtvec, csr_mepc, pc_exe, exe_valid, stall, is_mret,
    input  mip_mtip, trap_req, trap_pc, mepc_we, mepc_wdata, mcause_we,
           mcause_wdata, mstatus_we, mstatus_mie_wdata, mstatus_mpie_wdata
  );

  modport slave (
    input  timer_interrupt, csr_mstatus_mie, csr_mstatus_mpie, csr_mie_mtie,
           csr_mtvec, csr_mepc, pc_exe, exe_valid, stall, is_mret,
    output mip_mtip, trap_req, trap_pc, mepc_we, mepc_wdata, mcause_we,
           mcause_wdata, mstatus_we, mstatus_mie_wdata, mstatus_mpie_wdata
  );
endinterface

// File: rtl/timer_irq_handler.sv
// Machine-mode timer interrupt responder for the 3-stage pipeline.
// Synchronizes the timer line, waits for an execute-stage boundary and issues a
// one-cycle trap (flush, redirect, mepc/mcause/mstatus writes); also executes mret.
// Optional feature macro: TIMER_IRQ_VECTORED_EN (vectored mtvec mode, cause 7 offset).
// SYNC_STAGES legal range is 2..3.
module timer_irq_handler #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] MCAUSE_MTI  = 32'h8000_0007
) (
  input logic                clk,
  input logic                rst,
  timer_irq_handler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_TAKE = 2'd2,
    S_RET  = 2'd3
  } state_t;

  // Redirect target for a timer trap; mode bits are masked off the base.
  function automatic logic [31:0] trap_vector(input logic [31:0] mtvec);
    logic [31:0] base;
    base = mtvec & 32'hFFFF_FFFC;
`ifdef TIMER_IRQ_VECTORED_EN
    if (mtvec[1:0] == 2'b01) begin
      return base + 32'd28;
    end
`endif
    return base;
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  state_t                 w_next;
  logic                   w_qual;
  logic                   w_boundary;

  logic                   r_trap_req,   w_trap_req;
  logic [31:0]            r_trap_pc,    w_trap_pc;
  logic                   r_mepc_we,    w_mepc_we;
  logic [31:0]            r_mepc_wdata, w_mepc_wdata;
  logic                   r_mcause_we,  w_mcause_we;
  logic [31:0]            r_mcause_wd,  w_mcause_wd;
  logic                   r_mstatus_we, w_mstatus_we;
  logic                   r_mie_wd,     w_mie_wd;
  logic                   r_mpie_wd,    w_mpie_wd;

  // Timer line crosses into the core clock through SYNC_STAGES flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.timer_interrupt};
    end
  end

  assign bus.mip_mtip = r_sync[SYNC_STAGES-1];
  assign w_qual       = r_sync[SYNC_STAGES-1] & bus.csr_mstatus_mie & bus.csr_mie_mtie;
  assign w_boundary   = bus.exe_valid & ~bus.stall;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; an mret at a boundary wins over a pending interrupt.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_boundary && bus.is_mret) w_next = S_RET;
        else if (w_qual)               w_next = S_PEND;
      end
      S_PEND: begin
        if (w_boundary && bus.is_mret) w_next = S_RET;
        else if (!w_qual)              w_next = S_IDLE;
        else if (w_boundary)           w_next = S_TAKE;
      end
      S_TAKE:  w_next = S_IDLE;
      S_RET:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output values for the next cycle, captured at the decision edge.
  always_comb begin
    w_trap_req   = 1'b0;
    w_trap_pc    = '0;
    w_mepc_we    = 1'b0;
    w_mepc_wdata = '0;
    w_mcause_we  = 1'b0;
    w_mcause_wd  = '0;
    w_mstatus_we = 1'b0;
    w_mie_wd     = 1'b0;
    w_mpie_wd    = 1'b0;
    if (w_next == S_TAKE) begin
      w_trap_req   = 1'b1;
      w_trap_pc    = trap_vector(bus.csr_mtvec);
      w_mepc_we    = 1'b1;
      w_mepc_wdata = bus.pc_exe;
      w_mcause_we  = 1'b1;
      w_mcause_wd  = MCAUSE_MTI;
      w_mstatus_we = 1'b1;
      w_mie_wd     = 1'b0;
      w_mpie_wd    = bus.csr_mstatus_mie;
    end else if (w_next == S_RET) begin
      w_trap_req   = 1'b1;
      w_trap_pc    = bus.csr_mepc & 32'hFFFF_FFFC;
      w_mstatus_we = 1'b1;
      w_mie_wd     = bus.csr_mstatus_mpie;
      w_mpie_wd    = 1'b1;
    end
  end

  // Registered outputs; every one is cleared by reset, data included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_trap_req   <= 1'b0;
      r_trap_pc    <= '0;
      r_mepc_we    <= 1'b0;
      r_mepc_wdata <= '0;
      r_mcause_we  <= 1'b0;
      r_mcause_wd  <= '0;
      r_mstatus_we <= 1'b0;
      r_mie_wd     <= 1'b0;
      r_mpie_wd    <= 1'b0;
    end else begin
      r_trap_req   <= w_trap_req;
      r_trap_pc    <= w_trap_pc;
      r_mepc_we    <= w_mepc_we;
      r_mepc_wdata <= w_mepc_wdata;
      r_mcause_we  <= w_mcause_we;
      r_mcause_wd  <= w_mcause_wd;
      r_mstatus_we <= w_mstatus_we;
      r_mie_wd     <= w_mie_wd;
      r_mpie_wd    <= w_mpie_wd;
    end
  end

  assign bus.trap_req           = r_trap_req;
  assign bus.trap_pc            = r_trap_pc;
  assign bus.mepc_we            = r_mepc_we;
  assign bus.mepc_wdata         = r_mepc_wdata;
  assign bus.mcause_we          = r_mcause_we;
  assign bus.mcause_wdata       = r_mcause_wd;
  assign bus.mstatus_we         = r_mstatus_we;
  assign bus.mstatus_mie_wdata  = r_mie_wd;
  assign bus.mstatus_mpie_wdata = r_mpie_wd;

endmodule

// File: tb/tb_timer_irq_handler.sv
// Bench for timer_irq_handler: directed scenarios, an abstract behavioural model
// compared every cycle, and a small csr_reg stand-in that applies the DUT's writes.
module tb_timer_irq_handler;
  localparam int SYNC = 2;
`ifdef TIMER_IRQ_VECTORED_EN
  localparam logic [31:0] VEC_EXP = 32'h0000_011C;
`else
  localparam logic [31:0] VEC_EXP = 32'h0000_0100;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  timer_irq_handler_if bus();

  timer_irq_handler #(.SYNC_STAGES(SYNC), .MCAUSE_MTI(32'h8000_0007)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stimulus
  logic        t_timer = 0, t_mtie = 0, t_valid = 0, t_stall = 0, t_mret = 0;
  logic [31:0] t_mtvec = 0, t_pc = 0;
  logic        sw_we = 0, sw_mie = 0, sw_mpie = 0;
  logic [31:0] sw_mepc = 0;

  // csr_reg stand-in
  logic        c_mie, c_mpie;
  logic [31:0] c_mepc;

  assign bus.timer_interrupt  = t_timer;
  assign bus.csr_mstatus_mie  = c_mie;
  assign bus.csr_mstatus_mpie = c_mpie;
  assign bus.csr_mie_mtie     = t_mtie;
  assign bus.csr_mtvec        = t_mtvec;
  assign bus.csr_mepc         = c_mepc;
  assign bus.pc_exe           = t_pc;
  assign bus.exe_valid        = t_valid;
  assign bus.stall            = t_stall;
  assign bus.is_mret          = t_mret;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_mie  <= 1'b0;
      c_mpie <= 1'b0;
      c_mepc <= 32'h0;
    end else begin
      if (bus.mstatus_we) begin
        c_mie  <= bus.mstatus_mie_wdata;
        c_mpie <= bus.mstatus_mpie_wdata;
      end else if (sw_we) begin
        c_mie  <= sw_mie;
        c_mpie <= sw_mpie;
      end
      if (bus.mepc_we)   c_mepc <= bus.mepc_wdata;
      else if (sw_we)    c_mepc <= sw_mepc;
    end
  end

  // Behavioural model: mip is the timer line delayed SYNC edges; a pending
  // interrupt fires on a boundary, mret at a boundary fires first, and every
  // pulse is followed by one quiet cycle.
  function automatic logic [31:0] model_vec(input logic [31:0] mtvec);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
`ifdef TIMER_IRQ_VECTORED_EN
    if (mtvec[1:0] == 2'b01) return base + 32'd4 * 32'd7;
`endif
    return base;
  endfunction

  logic [SYNC-1:0] hist;
  logic            m_pend, m_cool;
  logic            e_req, e_mepc_we, e_mcause_we, e_ms_we, e_mie_wd, e_mpie_wd;
  logic [31:0]     e_pc, e_mepc_wd, e_mcause_wd;
  logic            e_mip;
  assign e_mip = hist[SYNC-1];

  always @(posedge clk or negedge rst) begin : model
    logic q, b;
    if (!rst) begin
      hist <= '0; m_pend <= 0; m_cool <= 0;
      e_req <= 0; e_pc <= 0; e_mepc_we <= 0; e_mepc_wd <= 0; e_mcause_we <= 0;
      e_mcause_wd <= 0; e_ms_we <= 0; e_mie_wd <= 0; e_mpie_wd <= 0;
    end else begin
      q = e_mip & c_mie & t_mtie;
      b = t_valid & ~t_stall;
      e_req <= 0; e_pc <= 0; e_mepc_we <= 0; e_mepc_wd <= 0; e_mcause_we <= 0;
      e_mcause_wd <= 0; e_ms_we <= 0; e_mie_wd <= 0; e_mpie_wd <= 0;
      if (m_cool) begin
        m_cool <= 0; m_pend <= 0;
      end else if (b && t_mret) begin
        e_req <= 1; e_pc <= {c_mepc[31:2], 2'b00};
        e_ms_we <= 1; e_mie_wd <= c_mpie; e_mpie_wd <= 1;
        m_cool <= 1; m_pend <= 0;
      end else if (m_pend && q && b) begin
        e_req <= 1; e_pc <= model_vec(t_mtvec);
        e_mepc_we <= 1; e_mepc_wd <= t_pc;
        e_mcause_we <= 1; e_mcause_wd <= 32'h8000_0007;
        e_ms_we <= 1; e_mie_wd <= 0; e_mpie_wd <= c_mie;
        m_cool <= 1; m_pend <= 0;
      end else begin
        m_pend <= q;
      end
      hist <= {hist[SYNC-2:0], t_timer};
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock; outputs are compared with the model on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("mip_mtip",     {31'b0, bus.mip_mtip},           {31'b0, e_mip});
    chk("trap_req",     {31'b0, bus.trap_req},           {31'b0, e_req});
    chk("trap_pc",      bus.trap_pc,                     e_pc);
    chk("mepc_we",      {31'b0, bus.mepc_we},            {31'b0, e_mepc_we});
    chk("mepc_wdata",   bus.mepc_wdata,                  e_mepc_wd);
    chk("mcause_we",    {31'b0, bus.mcause_we},          {31'b0, e_mcause_we});
    chk("mcause_wdata", bus.mcause_wdata,                e_mcause_wd);
    chk("mstatus_we",   {31'b0, bus.mstatus_we},         {31'b0, e_ms_we});
    chk("mie_wdata",    {31'b0, bus.mstatus_mie_wdata},  {31'b0, e_mie_wd});
    chk("mpie_wdata",   {31'b0, bus.mstatus_mpie_wdata}, {31'b0, e_mpie_wd});
  endtask

  task automatic csr_write(input logic mie, input logic mpie, input logic [31:0] mepc);
    sw_mie = mie; sw_mpie = mpie; sw_mepc = mepc; sw_we = 1'b1;
    tick();
    sw_we = 1'b0;
  endtask

  task automatic wait_trap(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.trap_req && n < max);
    if (!bus.trap_req) begin
      checks++;
      errors++;
      $display("FAIL wait_trap: no trap_req within %0d cycles", max);
    end
  endtask

  initial begin
    int n, total, spurious;
    // Reset and basic trap
    repeat (3) tick();
    chk("rst_trap_req",   {31'b0, bus.trap_req}, 32'h0);
    chk("rst_trap_pc",    bus.trap_pc,           32'h0);
    chk("rst_mcause_wd",  bus.mcause_wdata,      32'h0);
    chk("rst_mip",        {31'b0, bus.mip_mtip}, 32'h0);
    rst = 1'b1;
    t_mtie = 1; t_mtvec = 32'h100; t_valid = 1; t_stall = 0; t_pc = 32'h40;
    csr_write(1'b1, 1'b0, 32'h0);
    t_timer = 1;
    wait_trap(20, n);
    chk("lat_basic",      n,                     SYNC + 2);
    chk("basic_trap_pc",  bus.trap_pc,           32'h100);
    chk("basic_mepc",     bus.mepc_wdata,        32'h40);
    chk("basic_mcause",   bus.mcause_wdata,      32'h8000_0007);
    chk("basic_mie_wd",   {31'b0, bus.mstatus_mie_wdata},  32'h0);
    chk("basic_mpie_wd",  {31'b0, bus.mstatus_mpie_wdata}, 32'h1);
    tick();
    chk("csr_mie_after",  {31'b0, c_mie},  32'h0);
    chk("csr_mpie_after", {31'b0, c_mpie}, 32'h1);
    chk("no_reentry",     {31'b0, bus.trap_req}, 32'h0);

    // Masked interrupt
    spurious = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.trap_req) spurious++;
    end
    chk("masked_no_trap", spurious, 0);
    chk("masked_mip",     {31'b0, bus.mip_mtip}, 32'h1);
    csr_write(1'b1, 1'b1, 32'h40);
    wait_trap(10, n);
    chk("lat_unmask",     n, 2);
    tick();

    // Stall hold-off
    t_stall = 1; t_pc = 32'h60;
    csr_write(1'b1, 1'b1, 32'h40);
    total = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
    end
    t_stall = 0; t_pc = 32'h80;
    wait_trap(10, n);
    chk("lat_stall",      total + n, 7);
    chk("stall_mepc",     bus.mepc_wdata, 32'h80);
    tick();

    // mret return and re-entry
    csr_write(1'b0, 1'b1, 32'h44);
    t_mret = 1;
    tick();
    chk("ret_req",        {31'b0, bus.trap_req},           32'h1);
    chk("ret_pc",         bus.trap_pc,                     32'h44);
    chk("ret_mie_wd",     {31'b0, bus.mstatus_mie_wdata},  32'h1);
    chk("ret_mpie_wd",    {31'b0, bus.mstatus_mpie_wdata}, 32'h1);
    chk("ret_mepc_we",    {31'b0, bus.mepc_we},            32'h0);
    t_mret = 0;
    wait_trap(10, n);
    chk("lat_reentry",    n, 3);
    chk("reentry_mepc",   bus.mepc_wdata, 32'h80);
    tick();

    // Simultaneous mret and qualified interrupt
    t_valid = 0;
    csr_write(1'b1, 1'b1, 32'h44);
    tick();
    t_valid = 1; t_mret = 1;
    tick();
    chk("sim_req",        {31'b0, bus.trap_req},  32'h1);
    chk("sim_mcause_we",  {31'b0, bus.mcause_we}, 32'h0);
    chk("sim_pc",         bus.trap_pc,            32'h44);
    t_mret = 0;
    wait_trap(10, n);
    chk("sim_followup",   n, 3);
    chk("sim_follow_pc",  bus.trap_pc, 32'h100);
    tick();

    // Vectored mode
    t_mtvec = 32'h101;
    csr_write(1'b1, 1'b1, 32'h0);
    wait_trap(10, n);
    chk("vec_lat",        n, 2);
    chk("vec_pc",         bus.trap_pc, VEC_EXP);
    tick();

    // Reset during PEND
    t_valid = 0;
    csr_write(1'b1, 1'b1, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_async_mip",  {31'b0, bus.mip_mtip}, 32'h0);
    chk("rst_async_req",  {31'b0, bus.trap_req}, 32'h0);
    tick();
    tick();
    rst = 1'b1; t_valid = 1;
    spurious = 0;
    tick();
    chk("post_rst_mip0",  {31'b0, bus.mip_mtip}, 32'h0);
    if (bus.trap_req) spurious++;
    tick();
    chk("post_rst_mip1",  {31'b0, bus.mip_mtip}, 32'h1);
    if (bus.trap_req) spurious++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.trap_req) spurious++;
    end
    chk("post_rst_none",  spurious, 0);
    csr_write(1'b1, 1'b0, 32'h0);
    wait_trap(10, n);
    chk("post_rst_lat",   n, 2);
    chk("post_rst_pc",    bus.trap_pc, VEC_EXP);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_irq_handler.md
# timer_irq_handler

Machine-mode timer interrupt responder between the external `timer` block and the 3-stage pipeline.
- Synchronizes `timer_interrupt` and qualifies it against `mstatus.MIE` and `mie.MTIE`.
- Waits for a valid execute-stage instruction boundary, then issues a one-cycle trap: pipeline flush, PC redirect, and CSR writes for `mepc`, `mcause` and `mstatus`.
- Also executes `mret`.
- Sits beside `csr_reg`; it replaces ad-hoc interrupt logic in the core.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for `timer_interrupt`, legal values 2–3.
- `MCAUSE_MTI`, default 32'h8000_0007: value written to `mcause` on a timer trap.

Ports (reset is asynchronous, active-low):
- `clk` in 1: core clock.
- `rst` in 1: asynchronous reset, active-low.
- `timer_interrupt` in 1: level interrupt request from `timer`.
- `csr_mstatus_mie` in 1: current `mstatus.MIE`.
- `csr_mstatus_mpie` in 1: current `mstatus.MPIE`.
- `csr_mie_mtie` in 1: current `mie.MTIE`.
- `csr_mtvec` in 32: current `mtvec`.
- `csr_mepc` in 32: current `mepc`.
- `pc_exe` in 32: PC of the instruction in the execute stage.
- `exe_valid` in 1: the execute stage holds a real, non-bubble instruction.
- `stall` in 1: pipeline stalled this cycle.
- `is_mret` in 1: the execute-stage instruction is `mret`.
- `mip_mtip` out 1: synchronized pending bit, routed to `mip[7]`.
- `trap_req` out 1: one-cycle flush-and-redirect pulse.
- `trap_pc` out 32: redirect target, valid while `trap_req`.
- `mepc_we` out 1, `mepc_wdata` out 32: `mepc` write port.
- `mcause_we` out 1, `mcause_wdata` out 32: `mcause` write port.
- `mstatus_we` out 1, `mstatus_mie_wdata` out 1, `mstatus_mpie_wdata` out 1: `mstatus` write port.

## Operation
Synchronizer:
- `timer_interrupt` passes through `SYNC_STAGES` flops; the last stage drives `mip_mtip`.
- `qual = mip_mtip & csr_mstatus_mie & csr_mie_mtie`.
- `boundary = exe_valid & ~stall`.

State machine, states IDLE, PEND, TAKE, RET:
- IDLE → RET when `boundary & is_mret`. This has priority over a simultaneous `qual`.
- IDLE → PEND when `qual` holds and the RET condition does not.
- PEND → TAKE when `qual & boundary`.
- PEND → IDLE when `qual` drops; software cleared MIE or MTIE, or the timer deasserted. No trap is issued.
- PEND → RET when `boundary & is_mret`.
- TAKE → IDLE after 1 cycle.
- RET → IDLE after 1 cycle.

Actions in TAKE (all outputs registered, high for exactly that cycle):
- `trap_req=1` and `trap_pc` = trap vector (see Configuration).
- `mepc_we=1`, `mepc_wdata=pc_exe`, captured at the decision edge. The execute-stage instruction is squashed and re-executes after `mret`.
- `mcause_we=1`, `mcause_wdata=MCAUSE_MTI`.
- `mstatus_we=1`, `mstatus_mpie_wdata=csr_mstatus_mie` (1), `mstatus_mie_wdata=0`.

Actions in RET:
- `trap_req=1`, `trap_pc = {csr_mepc[31:2],2'b00}`.
- `mstatus_we=1`, `mstatus_mie_wdata=csr_mstatus_mpie`, `mstatus_mpie_wdata=1`.
- `mepc_we=0`, `mcause_we=0`.

After TAKE:
- MIE=0 blocks re-entry while the timer line stays high.
- Re-entry occurs only after `mret` restores MIE and `qual` is still true.

## Timing
Reset values:
- `state=IDLE`, synchronizer flops 0.
- Every output is 0, including `trap_pc`, `mepc_wdata` and `mcause_wdata`.

Interrupt latency:
- `timer_interrupt` high before edge N → `mip_mtip` high after edge N+SYNC_STAGES-1.
- PEND after edge N+SYNC_STAGES.
- `trap_req` high after edge N+SYNC_STAGES+1, provided `boundary` holds from then on.
- Each cycle of `~boundary` in PEND adds one cycle.

`mret` latency:
- `trap_req` is high during the cycle after the edge where `boundary & is_mret` was sampled.

Back-to-back:
- Minimum spacing between two `trap_req` pulses is 2 cycles.
- Outputs are never asserted in IDLE or PEND.

Reset mid-operation:
- `rst` low in any state forces IDLE and zero outputs immediately (asynchronously).
- A pending interrupt is re-detected only through the synchronizer after reset release.

## Configuration
`TIMER_IRQ_VECTORED_EN`:
- Defined: `mtvec[1:0]==2'b01` selects vectored mode, and `trap_pc = {csr_mtvec[31:2],2'b00} + 32'd28` (cause 7 × 4). Any other mode value gives the base address.
- Undefined: mode bits are ignored and `trap_pc = {csr_mtvec[31:2],2'b00}` always.

## Test plan
- **Reset and basic trap:** reset low 3 cycles, then MIE=MTIE=1, mtvec=0x100, `exe_valid=1`, `stall=0`, pc_exe=0x40, timer high → `trap_req` and `trap_pc=0x100` exactly SYNC_STAGES+2 cycles later; `mepc_wdata=0x40`; `mcause_wdata=0x80000007`; MIE→0, MPIE→1.
- **Masked interrupt:** MIE=0 and timer high for 50 cycles → `mip_mtip=1` and no `trap_req`. Then set MIE=1 → trap follows within 2 cycles.
- **Stall hold-off:** hold `stall=1` for 5 cycles in PEND → `trap_req` is delayed exactly 5 cycles; `mepc` equals the `pc_exe` present at the decision edge.
- **mret return:** `is_mret=1`, mepc=0x44, MPIE=1 → `trap_pc=0x44`, MIE→1, MPIE→1. If the timer is still high, a new trap follows SYNC-independent 3 cycles after RET.
- **Simultaneous events:** `is_mret` and `qual` on the same boundary → RET taken first; no `mcause` write in that pulse.
- **Vectored mode:** with `TIMER_IRQ_VECTORED_EN`, mtvec=0x101 → `trap_pc=0x11C`; without the macro → `trap_pc=0x100`. Also assert `rst` low during PEND → outputs return to 0 with no trap.
